// File: rtl/store_merge_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : store_merge_if
// Brief    : Store request handshake and word-memory bus for store_merge_unit.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface store_merge_if #(
  parameter int ADDR_W = 32
) ();
  logic              st_valid;
  logic              st_ready;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       store_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              fault;

  // Requester side; it also returns read data from the memory
  modport master (
    output st_valid, funct3, addr, store_data, mem_rdata,
    input  st_ready, mem_addr, mem_re, mem_we, mem_wdata, done, fault
  );

  modport slave (
    input  st_valid, funct3, addr, store_data, mem_rdata,
    output st_ready, mem_addr, mem_re, mem_we, mem_wdata, done, fault
  );
endinterface
`default_nettype wire

// File: rtl/store_merge_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : store_merge_unit
// Brief    : Turns SB/SH/SW stores into word writes, read-modify-write for
//            sub-word stores; misaligned or unknown stores raise a fault.
// Revision : 1.0
// ---------------------------------------------------------------------------
module store_merge_unit #(
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  store_merge_if.slave bus
);

  localparam logic [2:0] c_F3_SB = 3'b000;
  localparam logic [2:0] c_F3_SH = 3'b001;
  localparam logic [2:0] c_F3_SW = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            r_state;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [31:0]       r_wdata;
  logic              r_re;
  logic              r_we;
  logic              r_done;
  logic              r_fault;

  logic              w_sw_ok;
  logic              w_rmw;
  logic [31:0]       w_merged;

  // Classification of the request presented this cycle (used only on accept)
  always_comb begin
    w_sw_ok = (bus.funct3 == c_F3_SW) && (bus.addr[1:0] == 2'b00);
    w_rmw   = (bus.funct3 == c_F3_SB) ||
              ((bus.funct3 == c_F3_SH) && !bus.addr[0]);
  end

  always_comb begin
    w_merged = bus.mem_rdata;
    case (r_funct3)
      c_F3_SB: begin
        case (r_addr[1:0])
          2'd0: w_merged[7:0]   = r_data[7:0];
          2'd1: w_merged[15:8]  = r_data[7:0];
          2'd2: w_merged[23:16] = r_data[7:0];
          2'd3: w_merged[31:24] = r_data[7:0];
        endcase
      end
      c_F3_SH: begin
        if (r_addr[1]) begin
          w_merged[31:16] = r_data[15:0];
        end else begin
          w_merged[15:0] = r_data[15:0];
        end
      end
      c_F3_SW: w_merged = r_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_data   <= 32'h0;
      r_wdata  <= 32'h0;
      r_re     <= 1'b0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.st_valid) begin
            r_funct3 <= bus.funct3;
            r_addr   <= bus.addr;
            r_data   <= bus.store_data;
            if (w_sw_ok) begin
              r_state <= S_WRITE;
              r_wdata <= bus.store_data;
              r_we    <= 1'b1;
              r_done  <= 1'b1;
            end else if (w_rmw) begin
              r_state <= S_READ;
              r_re    <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_fault <= 1'b1;
            end
          end
        end
        S_READ: begin
          r_re    <= 1'b0;
          r_state <= S_MERGE;
        end
        // Read data arrives this cycle; the merged word goes straight to the write register
        S_MERGE: begin
          r_wdata <= w_merged;
          r_we    <= 1'b1;
          r_done  <= 1'b1;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_fault <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_re    <= 1'b0;
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_fault <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.st_ready  = (r_state == S_IDLE);
  assign bus.mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus.mem_re    = r_re;
  assign bus.mem_we    = r_we;
  assign bus.mem_wdata = r_wdata;
  assign bus.done      = r_done;
  assign bus.fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_store_merge_unit
// Brief    : Directed self-checking bench for store_merge_unit with a word memory model.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_store_merge_unit;

  logic clk;
  logic rst;

  store_merge_if #(.ADDR_W(32)) bus ();

  store_merge_unit #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_re     = 0;
  int n_we     = 0;
  int n_both   = 0;

  logic        pl_en;
  logic [31:0] pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [0:255];
  logic [31:0] log_addr [0:15];
  logic [31:0] log_data [0:15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: read data valid one cycle after mem_re; preload port for the bench
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr[9:2]] <= pl_data;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      log_addr[n_we[3:0]]    <= bus.mem_addr;
      log_data[n_we[3:0]]    <= bus.mem_wdata;
    end
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    if (bus.mem_re) n_re <= n_re + 1;
    if (bus.mem_we) n_we <= n_we + 1;
    if (bus.mem_re && bus.mem_we) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Read-modify-write store; inputs are scrambled after accept to prove latching
  task automatic rmw(input string tag, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp);
    int re0;
    int we0;
    re0 = n_re;
    we0 = n_we;
    bus.st_valid = 1'b1; bus.funct3 = f3; bus.addr = a; bus.store_data = d;
    @(negedge clk);
    bus.st_valid = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'hFFFF_FFFC; bus.store_data = 32'hFFFF_FFFF;
    check({tag, " read re"}, {31'd0, bus.mem_re}, 32'd1);
    check({tag, " read addr"}, bus.mem_addr, {a[31:2], 2'b00});
    check({tag, " read ready"}, {31'd0, bus.st_ready}, 32'd0);
    @(negedge clk);
    check({tag, " merge re"}, {31'd0, bus.mem_re}, 32'd0);
    check({tag, " merge we"}, {31'd0, bus.mem_we}, 32'd0);
    @(negedge clk);
    check({tag, " write we"}, {31'd0, bus.mem_we}, 32'd1);
    check({tag, " write done"}, {31'd0, bus.done}, 32'd1);
    check({tag, " write wdata"}, bus.mem_wdata, exp);
    check({tag, " write addr"}, bus.mem_addr, {a[31:2], 2'b00});
    @(negedge clk);
    check({tag, " idle done"}, {31'd0, bus.done}, 32'd0);
    check({tag, " idle ready"}, {31'd0, bus.st_ready}, 32'd1);
    check({tag, " re count"}, n_re - re0, 32'd1);
    check({tag, " we count"}, n_we - we0, 32'd1);
  endtask

  task automatic bad_store(input string tag, input logic [2:0] f3, input logic [31:0] a);
    int re0;
    int we0;
    re0 = n_re;
    we0 = n_we;
    bus.st_valid = 1'b1; bus.funct3 = f3; bus.addr = a; bus.store_data = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.st_valid = 1'b0;
    check({tag, " fault"}, {31'd0, bus.fault}, 32'd1);
    check({tag, " done"}, {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    check({tag, " fault clear"}, {31'd0, bus.fault}, 32'd0);
    check({tag, " ready"}, {31'd0, bus.st_ready}, 32'd1);
    check({tag, " no mem access"}, (n_re - re0) + (n_we - we0), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int re0;
    int we0;
    rst = 1'b0;
    pl_en = 1'b0; pl_addr = 32'h0; pl_data = 32'h0;
    bus.st_valid = 1'b0; bus.funct3 = 3'b000; bus.addr = 32'h0; bus.store_data = 32'h0;

    @(negedge clk);
    check("reset mem_re", {31'd0, bus.mem_re}, 32'd0);
    check("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset fault", {31'd0, bus.fault}, 32'd0);
    check("reset mem_addr", bus.mem_addr, 32'h0);
    check("reset mem_wdata", bus.mem_wdata, 32'h0);
    preload(32'h100, 32'hAABB_CCDD);
    rst = 1'b1;
    @(negedge clk);
    check("ready after reset", {31'd0, bus.st_ready}, 32'd1);

    rmw("sb 0x102", 3'b000, 32'h102, 32'h0000_00EE, 32'hAAEE_CCDD);
    check("sb memory word", mem[8'h40], 32'hAAEE_CCDD);
    preload(32'h100, 32'hAABB_CCDD);
    rmw("sh 0x102", 3'b001, 32'h102, 32'h0000_1234, 32'h1234_CCDD);
    preload(32'h100, 32'hAABB_CCDD);
    rmw("sh 0x100", 3'b001, 32'h100, 32'h0000_1234, 32'hAABB_1234);
    rmw("sb 0x101", 3'b000, 32'h100 | 32'h1, 32'hFFFF_FF77, 32'hAABB_7734);

    // Aligned word store skips the read
    re0 = n_re;
    bus.st_valid = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h104; bus.store_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.st_valid = 1'b0;
    check("sw we", {31'd0, bus.mem_we}, 32'd1);
    check("sw done", {31'd0, bus.done}, 32'd1);
    check("sw wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("sw addr", bus.mem_addr, 32'h104);
    @(negedge clk);
    check("sw done clear", {31'd0, bus.done}, 32'd0);
    check("sw no read", n_re - re0, 32'd0);

    bad_store("sh 0x101", 3'b001, 32'h101);
    bad_store("sw 0x106", 3'b010, 32'h106);
    bad_store("funct3 011", 3'b011, 32'h100);

    // Reset while the read-modify-write is in MERGE
    preload(32'h100, 32'hAABB_CCDD);
    we0 = n_we;
    bus.st_valid = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h103; bus.store_data = 32'h0000_0055;
    @(negedge clk);
    bus.st_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort we", {31'd0, bus.mem_we}, 32'd0);
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort no write", n_we - we0, 32'd0);
    check("abort word", mem[8'h40], 32'hAABB_CCDD);
    check("abort ready", {31'd0, bus.st_ready}, 32'd1);

    // Back-to-back word stores with st_valid held high
    we0 = n_we;
    bus.st_valid = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h200; bus.store_data = 32'h1111_1111;
    @(negedge clk);
    check("b2b first done", {31'd0, bus.done}, 32'd1);
    check("b2b first addr", bus.mem_addr, 32'h200);
    bus.addr = 32'h204; bus.store_data = 32'h2222_2222;
    @(negedge clk);
    check("b2b idle ready", {31'd0, bus.st_ready}, 32'd1);
    check("b2b idle done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    bus.st_valid = 1'b0;
    check("b2b second done", {31'd0, bus.done}, 32'd1);
    check("b2b second addr", bus.mem_addr, 32'h204);
    check("b2b second wdata", bus.mem_wdata, 32'h2222_2222);
    @(negedge clk);
    check("b2b write count", n_we - we0, 32'd2);
    check("b2b order first", log_addr[we0[3:0]], 32'h200);
    check("b2b order second", log_addr[4'(we0 + 1)], 32'h204);
    check("b2b first data", log_data[we0[3:0]], 32'h1111_1111);
    check("b2b mem 0x204", mem[8'h81], 32'h2222_2222);

    check("re/we never together", n_both, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
